// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot-time ROM loader: FSM encoding, frame marker
// and UART bit-timing helper.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } load_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises rx, rejects short start glitches and emits a
// one-cycle byte_valid or frame_err per received character.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shreg, shreg_d;
  logic [7:0]       byte_data_d;
  logic             byte_valid_d, frame_err_d;
  logic             rx_meta, rx_sync, rx_prev;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      shreg      <= shreg_d;
      byte_valid <= byte_valid_d;
      byte_data  <= byte_data_d;
      frame_err  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt + CNT_W'(1);
    bit_idx_d    = bit_idx;
    shreg_d      = shreg;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data;
    frame_err_d  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_sync) state_d = RX_START;
      end
      RX_START: begin
        // A start bit still low at mid-bit is genuine; anything else is noise
        if (cnt == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_d     = '0;
          shreg_d   = {rx_sync, shreg[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shreg;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/rom_uart_loader.sv
// Boot loader: receives a framed, checksummed program image over UART, writes it
// into the instruction ROM and releases the core once the image is verified.
module rom_uart_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned ADDR_W    = 12,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned DEPTH        = 32'(1) << ADDR_W;

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  load_state_e       state, state_d;
  logic [15:0]       len, len_d;
  logic [7:0]        sum, sum_d;
  logic [ADDR_W-1:0] word_idx, word_idx_d;
  logic [1:0]        byte_idx, byte_idx_d;
  logic [31:0]       word_buf, word_buf_d;
  logic              rom_we_d, core_hold_d, load_done_d, load_err_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [31:0]       rom_wdata_d;
  logic [15:0]       len_hi_val;

  assign len_hi_val = {byte_data, len[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      sum       <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      core_hold <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_d;
      len       <= len_d;
      sum       <= sum_d;
      word_idx  <= word_idx_d;
      byte_idx  <= byte_idx_d;
      word_buf  <= word_buf_d;
      rom_we    <= rom_we_d;
      rom_addr  <= rom_addr_d;
      rom_wdata <= rom_wdata_d;
      core_hold <= core_hold_d;
      load_done <= load_done_d;
      load_err  <= load_err_d;
    end
  end

  always_comb begin
    state_d     = state;
    len_d       = len;
    sum_d       = sum;
    word_idx_d  = word_idx;
    byte_idx_d  = byte_idx;
    word_buf_d  = word_buf;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr;
    rom_wdata_d = rom_wdata;

    if (frame_err && (state == ST_LEN_LO || state == ST_LEN_HI ||
                      state == ST_DATA   || state == ST_CSUM)) begin
      state_d = ST_ERR;
    end else if (byte_valid) begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (byte_data == SYNC_BYTE) begin
            state_d    = ST_LEN_LO;
            sum_d      = '0;
            word_idx_d = '0;
            byte_idx_d = '0;
          end
        end
        ST_LEN_LO: begin
          len_d   = {len[15:8], byte_data};
          state_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          len_d = len_hi_val;
          if (32'(len_hi_val) > DEPTH)  state_d = ST_ERR;
          else if (len_hi_val == 16'd0) state_d = ST_CSUM;
          else                          state_d = ST_DATA;
        end
        ST_DATA: begin
          word_buf_d[{byte_idx, 3'b000} +: 8] = byte_data;
          sum_d      = sum + byte_data;
          byte_idx_d = byte_idx + 2'd1;
          // Fourth byte completes a little-endian word: commit it to ROM
          if (byte_idx == 2'd3) begin
            rom_we_d    = 1'b1;
            rom_addr_d  = word_idx;
            rom_wdata_d = word_buf_d;
            word_idx_d  = word_idx + ADDR_W'(1);
            if (32'(word_idx) == 32'(len) - 32'd1) state_d = ST_CSUM;
          end
        end
        ST_CSUM: state_d = (byte_data == sum) ? ST_DONE : ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end

    core_hold_d = (state_d != ST_DONE);
    load_done_d = (state_d == ST_DONE);
    load_err_d  = (state_d == ST_ERR);
  end

endmodule

// File: tb/tb_rom_uart_loader.sv
// Directed bench for rom_uart_loader at 16 clocks per UART bit.
module tb_rom_uart_loader;

  logic        clk;
  logic        rst;
  logic        uart_rx;
  logic        rom_we;
  logic [11:0] rom_addr;
  logic [31:0] rom_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  int compared   = 0;
  int mismatched = 0;
  int we_cnt     = 0;
  int we_wide    = 0;
  int base;
  logic        we_prev = 1'b0;
  logic [11:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  logic [7:0]  good_frame [0:11];

  rom_uart_loader #(
    .CLK_FREQ (1600000),
    .BAUD     (100000),
    .ADDR_W   (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write strobe and flag any strobe wider than one cycle
  always @(negedge clk) begin
    if (rom_we) begin
      log_addr[we_cnt % 64] <= rom_addr;
      log_data[we_cnt % 64] <= rom_wdata;
      we_cnt <= we_cnt + 1;
      if (we_prev) we_wide <= we_wide + 1;
    end
    we_prev <= rom_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_good_frame(input logic [7:0] csum);
    for (int i = 0; i < 11; i++) send_byte(good_frame[i], 1'b1);
    send_byte(csum, 1'b1);
  endtask

  initial begin
    good_frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                   8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    rst     = 1'b0;
    uart_rx = 1'b1;

    // 1. asynchronous reset seen before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_rom_we",    32'(rom_we),    32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err",  32'(load_err),  32'd0);
    check("rst_rom_addr",  32'(rom_addr),  32'd0);
    check("rst_rom_wdata", rom_wdata,      32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 2. junk bytes ignored, then a good two-word load
    base = we_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("junk_no_we",    32'(we_cnt - base), 32'd0);
    check("junk_hold",     32'(core_hold),     32'd1);
    send_good_frame(8'hB6);
    check("good_we_count", 32'(we_cnt - base), 32'd2);
    check("good_addr0",    32'(log_addr[base % 64]),       32'd0);
    check("good_data0",    log_data[base % 64],            32'h0000_0013);
    check("good_addr1",    32'(log_addr[(base + 1) % 64]), 32'd1);
    check("good_data1",    log_data[(base + 1) % 64],      32'h0010_0093);
    check("good_done",     32'(load_done), 32'd1);
    check("good_hold",     32'(core_hold), 32'd0);
    check("good_err",      32'(load_err),  32'd0);

    // 3. bad checksum, then recovery with the correct frame
    send_good_frame(8'hB7);
    check("badsum_err",  32'(load_err),  32'd1);
    check("badsum_hold", 32'(core_hold), 32'd1);
    check("badsum_done", 32'(load_done), 32'd0);
    send_good_frame(8'hB6);
    check("resend_done", 32'(load_done), 32'd1);
    check("resend_err",  32'(load_err),  32'd0);

    // 4a. 8-clock low glitches in IDLE and mid-header must not form bytes
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b0; repeat (8) @(negedge clk); uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_idle_hold", 32'(core_hold), 32'd1);
    check("glitch_idle_err",  32'(load_err),  32'd0);
    send_byte(8'hA5, 1'b1);
    uart_rx = 1'b0; repeat (8) @(negedge clk); uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("glitch_hdr_done", 32'(load_done), 32'd1);

    // 4b. stop-bit error in DATA aborts the load
    base = we_cnt;
    for (int i = 0; i < 8; i++) send_byte(good_frame[i], 1'b1);
    send_byte(8'h00, 1'b0);
    check("ferr_err",  32'(load_err),  32'd1);
    check("ferr_hold", 32'(core_hold), 32'd1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hB6, 1'b1);
    check("ferr_we_count", 32'(we_cnt - base), 32'd1);
    check("ferr_still_err", 32'(load_err), 32'd1);

    // 5a. empty image
    base = we_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("empty_done",     32'(load_done),     32'd1);
    check("empty_we_count", 32'(we_cnt - base), 32'd0);

    // 5b. N = 4097 exceeds the ROM
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    check("len_lo_pending", 32'(load_err), 32'd0);
    send_byte(8'h10, 1'b1);
    check("oversize_err",  32'(load_err),  32'd1);
    check("oversize_hold", 32'(core_hold), 32'd1);

    // 5c. reset in the middle of DATA, then a clean load from IDLE
    for (int i = 0; i < 5; i++) send_byte(good_frame[i], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_hold", 32'(core_hold), 32'd1);
    check("midrst_err",  32'(load_err),  32'd0);
    check("midrst_done", 32'(load_done), 32'd0);
    check("midrst_we",   32'(rom_we),    32'd0);
    check("midrst_addr", 32'(rom_addr),  32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    base = we_cnt;
    send_good_frame(8'hB6);
    check("post_rst_done",  32'(load_done),     32'd1);
    check("post_rst_count", 32'(we_cnt - base), 32'd2);
    check("we_pulse_width", 32'(we_wide),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rom_uart_loader.md
Name: rom_uart_loader

Overview:
- Boot-time program loader sitting directly upstream of the SoC instruction ROM.
- Receives a framed program image over a UART RX line and writes it word-by-word into the ROM write port.
- Holds the core in reset (core_hold) until a complete, checksum-verified image is in place.
- Replaces the simulation-only file preload of ROM contents for FPGA bring-up.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated.
- ADDR_W, 12: ROM word-address width; DEPTH = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- uart_rx  in  1  serial input; idles high; asynchronous to clk.
- rom_we  out  1  one-cycle ROM write strobe.
- rom_addr  out  ADDR_W  ROM word address.
- rom_wdata  out  32  ROM write data.
- core_hold  out  1  1 = keep core in reset.
- load_done  out  1  image loaded and verified.
- load_err  out  1  last load failed.

Behaviour:
- Reset values: rom_we=0, rom_addr=0, rom_wdata=0, core_hold=1, load_done=0, load_err=0.
- Reset asserted mid-load aborts everything and returns to these values. ROM contents already written are left as they are.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), then N words of 4 bytes each, little-endian, then CSUM.
  - CSUM = 8-bit sum modulo 256 of all 4N data bytes.
  - Sync and length bytes are excluded from CSUM.
- UART RX:
  - 2-FF synchroniser on uart_rx.
  - A falling edge starts a frame. The line is re-sampled at CLKS_PER_BIT/2; if it is high, the event is a glitch and RX returns to idle with no output.
  - 8 data bits are sampled LSB first at bit centres, then the stop bit.
  - Produces a one-cycle byte_valid with the byte value, or a one-cycle frame_err if the stop bit is 0.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
  - IDLE: bytes other than SYNC_BYTE are ignored. SYNC_BYTE -> LEN_LO; clears the running sum, word index and byte index.
  - LEN_LO -> LEN_HI.
  - LEN_HI: N > DEPTH -> ERR; N == 0 -> CSUM; otherwise -> DATA.
  - DATA: each byte is shifted into bits [8*k+7:8*k] (k = byte index 0..3) and added to the running sum.
    - On the 4th byte, rom_we pulses high for exactly 1 cycle in the cycle after byte_valid, with rom_addr = word index and rom_wdata = the assembled word.
    - Word index then increments. After word N-1 -> CSUM.
  - CSUM: received byte == running sum -> DONE, else -> ERR.
  - DONE: core_hold=0, load_done=1, load_err=0.
  - ERR: core_hold=1, load_done=0, load_err=1.
  - In DONE or ERR, a SYNC_BYTE starts a new load: goes to LEN_LO, core_hold=1, load_done=0, load_err=0. Other bytes are ignored.
- frame_err in LEN_LO, LEN_HI, DATA or CSUM -> ERR. frame_err in IDLE, DONE or ERR is ignored.
- No inter-byte timeout: a stalled host leaves the FSM waiting with core_hold=1.
- rom_addr and rom_wdata hold their last values when rom_we=0.

Decomposition:
- Shared package rom_loader_pkg holds:
  - the FSM state encoding (typedef enum, 3 bits);
  - the SYNC_BYTE default;
  - the function clks_per_bit(CLK_FREQ, BAUD).
- One natural sub-module, uart_rx_byte (parameter CLKS_PER_BIT; ports clk, rst, rx, byte_valid, byte_data, frame_err). It is reused later by the UART peripheral.

Test Plan:
Use CLK_FREQ=1600000 and BAUD=100000, giving CLKS_PER_BIT=16.
1. Reset: assert rst async mid-clock -> core_hold=1, rom_we=0, load_done=0, load_err=0 immediately, before any clk edge.
2. Good load: send 0x00, 0xFF (ignored), then A5 02 00 13 00 00 00 93 00 10 00 B6.
   - Expect exactly two rom_we pulses: addr0=0x00000013, then addr1=0x00100093.
   - Then load_done=1, core_hold=0.
3. Bad checksum: the same frame with CSUM=B7 -> load_err=1, core_hold=1. Resend the correct frame -> load_done=1, load_err=0.
4. Line noise: an 8-clock low pulse on uart_rx in IDLE -> no byte accepted. A byte with stop bit 0 during DATA -> ERR, no further rom_we.
5. Edge counts:
   - A5 00 00 00 -> DONE with zero rom_we pulses.
   - A5 01 10 (N=4097 > 4096) -> ERR right after LEN_HI.
   - rst mid-DATA -> returns to IDLE with core_hold=1.
